// File: rtl/sdi_sync_to_fvlv.sv
// Converts edge-based SDI hsync/vsync timing into FV/LV/DE cropped to an active window,
// with frame counting, lock status and malformed line/frame pulses.
module sdi_sync_to_fvlv #(
    parameter int DATA_W   = 8,
    parameter int H_BP     = 4,
    parameter int H_ACTIVE = 2560,
    parameter int V_BP     = 20,
    parameter int V_ACTIVE = 720
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              vsync_i,
    input  logic              hsync_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              fv_o,
    output logic              lv_o,
    output logic              de_o,
    output logic [DATA_W-1:0] data_o,
    output logic [15:0]       frame_cnt_o,
    output logic              locked_o,
    output logic              err_line_o,
    output logic              err_frame_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_VBLANK, S_HPORCH, S_LINE, S_HGAP, S_FEND
    } state_t;

    localparam logic [11:0] H_BP_M1  = 12'(H_BP - 1);
    localparam logic [11:0] H_ACT_M1 = 12'(H_ACTIVE - 1);
    localparam logic [10:0] V_BP_M1  = 11'((V_BP > 0) ? V_BP - 1 : 0);
    localparam logic [10:0] V_ACT_M1 = 11'(V_ACTIVE - 1);
    // With a one-clock porch the line starts right on the cycle after hs_fall.
    localparam state_t      LINE_ENTRY = (H_BP == 1) ? S_LINE : S_HPORCH;
    localparam logic [11:0] CNT_ENTRY  = (H_BP == 1) ? 12'd0 : 12'd1;

    logic              vs_q, hs_q, vs_prev_q, hs_prev_q;
    logic [DATA_W-1:0] data_q, data_s_q, data_o_q, data_o_d;
    logic              act_q, act;
    state_t            state_q, state_d;
    logic [11:0]       cnt_q, cnt_d;
    logic [10:0]       line_cnt_q, line_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              locked_q, locked_d;
    logic              fv_q, fv_d, lv_q, lv_d;
    logic              err_line_q, err_frame_q;
    logic              hs_fall, vs_rise, in_frame, frame_abort, line_abort, frame_done;

    assign hs_fall     = hs_prev_q & ~hs_q;
    assign vs_rise     = vs_q & ~vs_prev_q;
    assign in_frame    = (state_q == S_HPORCH) || (state_q == S_LINE) || (state_q == S_HGAP);
    assign frame_abort = vs_rise && in_frame;
    assign line_abort  = hs_fall && !frame_abort && ((state_q == S_HPORCH) || (state_q == S_LINE));
    assign frame_done  = (state_q == S_FEND) && cnt_q[0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            hs_prev_q   <= 1'b0;
            data_q      <= '0;
            data_s_q    <= '0;
            act_q       <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            data_o_q    <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            vs_q        <= vsync_i;
            hs_q        <= hsync_i;
            vs_prev_q   <= vs_q;
            hs_prev_q   <= hs_q;
            data_q      <= data_i;
            data_s_q    <= data_q;
            act_q       <= act;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            data_o_q    <= data_o_d;
            err_line_q  <= line_abort;
            err_frame_q <= frame_abort;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_cnt_d = line_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (vs_rise) begin
                    state_d    = S_VBLANK;
                    line_cnt_d = '0;
                end
            end
            S_VBLANK: begin
                // A repeated vsync restarts the blanking count.
                if (vs_rise) begin
                    line_cnt_d = '0;
                end else if (hs_fall) begin
                    if ((V_BP == 0) || (line_cnt_q == V_BP_M1)) begin
                        state_d    = LINE_ENTRY;
                        cnt_d      = CNT_ENTRY;
                        line_cnt_d = '0;
                    end else begin
                        line_cnt_d = line_cnt_q + 11'd1;
                    end
                end
            end
            S_HPORCH, S_LINE: begin
                if (frame_abort) begin
                    state_d    = S_VBLANK;
                    line_cnt_d = '0;
                end else if (hs_fall) begin
                    if (line_cnt_q == V_ACT_M1) begin
                        state_d = S_FEND;
                        cnt_d   = '0;
                    end else begin
                        state_d    = LINE_ENTRY;
                        cnt_d      = CNT_ENTRY;
                        line_cnt_d = line_cnt_q + 11'd1;
                    end
                end else if (state_q == S_HPORCH) begin
                    if (cnt_q == H_BP_M1) begin
                        state_d = S_LINE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end else if (cnt_q == H_ACT_M1) begin
                    state_d = S_HGAP;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_HGAP: begin
                if (frame_abort) begin
                    state_d    = S_VBLANK;
                    line_cnt_d = '0;
                end else if (line_cnt_q == V_ACT_M1) begin
                    state_d = S_FEND;
                    cnt_d   = '0;
                end else if (hs_fall) begin
                    state_d    = LINE_ENTRY;
                    cnt_d      = CNT_ENTRY;
                    line_cnt_d = line_cnt_q + 11'd1;
                end
            end
            S_FEND: begin
                // Two cycles here so fv_o falls one cycle after the last lv_o.
                if (cnt_q[0]) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = 12'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act         = (state_q == S_LINE) && !line_abort && !frame_abort;
        lv_d        = act_q && !line_abort && !frame_abort;
        data_o_d    = lv_d ? data_s_q : '0;
        fv_d        = (state_d == S_HPORCH) || (state_d == S_LINE) ||
                      (state_d == S_HGAP) || (state_d == S_FEND);
        frame_cnt_d = frame_cnt_q + {15'd0, frame_done};
        frame_err_d = frame_err_q;
        if (state_d == S_VBLANK && state_q != S_VBLANK) begin
            frame_err_d = 1'b0;
        end else if (line_abort) begin
            frame_err_d = 1'b1;
        end
        locked_d = locked_q;
        if (line_abort || frame_abort) begin
            locked_d = 1'b0;
        end else if (frame_done && !frame_err_q) begin
            locked_d = 1'b1;
        end
    end

    assign fv_o        = fv_q;
    assign lv_o        = lv_q;
    assign de_o        = lv_q;
    assign data_o      = data_o_q;
    assign frame_cnt_o = frame_cnt_q;
    assign locked_o    = locked_q;
    assign err_line_o  = err_line_q;
    assign err_frame_o = err_frame_q;

endmodule
